// File: rtl/imm_pkg.sv
// rtl/imm_pkg.sv - opcode constants, format codes and skid-buffer state encoding
package imm_pkg;

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_REG    = 7'b0110011;

   localparam logic [2:0] F3_SLLI   = 3'b001;
   localparam logic [2:0] F3_SRXI   = 3'b101;

   typedef enum logic [2:0] {
      FMT_NONE  = 3'd0,
      FMT_I     = 3'd1,
      FMT_S     = 3'd2,
      FMT_B     = 3'd3,
      FMT_U     = 3'd4,
      FMT_J     = 3'd5,
      FMT_SHAMT = 3'd6
   } fmt_t;

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_TWO   = 2'd2
   } buf_state_t;

endpackage

// File: rtl/imm_fmt_decode.sv
// rtl/imm_fmt_decode.sv - combinational RV32I immediate and format decode
module imm_fmt_decode
   import imm_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [31:0]     instr,
   input  logic            signext,
   output logic [XLEN-1:0] imm,
   output fmt_t            fmt,
   output logic            illegal
);

   logic       ext;
   logic [2:0] funct3;

   assign ext    = instr[31] & signext;
   assign funct3 = instr[14:12];

   always_comb begin
      imm     = '0;
      fmt     = FMT_NONE;
      illegal = 1'b0;
      case (instr[6:0])
         OP_LOAD, OP_JALR: begin
            fmt = FMT_I;
            imm = {{(XLEN-12){ext}}, instr[31:20]};
         end
         OP_IMM: begin
            if (funct3 == F3_SLLI || funct3 == F3_SRXI) begin
               fmt      = FMT_SHAMT;
               imm[4:0] = instr[24:20];
               // RV32 has only a 5-bit shamt, so bit 25 set is unencodable there
               if (XLEN == 64) imm[5] = instr[25];
               else            illegal = instr[25];
            end else begin
               fmt = FMT_I;
               imm = {{(XLEN-12){ext}}, instr[31:20]};
            end
         end
         OP_STORE: begin
            fmt = FMT_S;
            imm = {{(XLEN-12){ext}}, instr[31:25], instr[11:7]};
         end
         OP_BRANCH: begin
            fmt = FMT_B;
            imm = {{(XLEN-13){ext}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
         end
         OP_LUI, OP_AUIPC: begin
            fmt       = FMT_U;
            imm       = {XLEN{ext}};
            imm[31:0] = {instr[31:12], 12'h000};
         end
         OP_JAL: begin
            fmt = FMT_J;
            imm = {{(XLEN-21){ext}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
         end
         OP_REG: begin
            fmt = FMT_NONE;
         end
         default: begin
            illegal = 1'b1;
         end
      endcase
   end

endmodule

// File: rtl/imm_gen_pipe.sv
// rtl/imm_gen_pipe.sv - immediate decoder behind a 2-entry skid buffer with illegal counter
module imm_gen_pipe
   import imm_pkg::*;
#(
   parameter int XLEN  = 32,
   parameter int CNT_W = 16
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_in_valid,
   output logic             o_in_ready,
   input  logic [31:0]      i_instr,
   input  logic             i_signext,
   output logic             o_out_valid,
   input  logic             i_out_ready,
   output logic [XLEN-1:0]  o_imm,
   output logic [2:0]       o_fmt,
   output logic             o_illegal,
   output logic [CNT_W-1:0] o_illegal_cnt,
   input  logic             i_cnt_clr
);

   logic [XLEN-1:0] dec_imm;
   fmt_t            dec_fmt;
   logic            dec_illegal;

   logic [XLEN-1:0] skid_imm;
   logic [2:0]      skid_fmt;
   logic            skid_illegal;

   buf_state_t      state;
   buf_state_t      state_next;
   logic            push;
   logic            pop;

   imm_fmt_decode #(.XLEN(XLEN)) u_decode (
      .instr   (i_instr),
      .signext (i_signext),
      .imm     (dec_imm),
      .fmt     (dec_fmt),
      .illegal (dec_illegal)
   );

   assign push = i_in_valid & o_in_ready;
   assign pop  = o_out_valid & i_out_ready;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) state <= ST_EMPTY;
      else       state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         ST_EMPTY: if (push) state_next = ST_ONE;
         ST_ONE: begin
            if (push && !pop)      state_next = ST_TWO;
            else if (pop && !push) state_next = ST_EMPTY;
         end
         ST_TWO:   if (pop) state_next = ST_ONE;
         default:  state_next = ST_EMPTY;
      endcase
   end

   always_comb begin
      o_out_valid = (state != ST_EMPTY);
      o_in_ready  = (state != ST_TWO);
   end

   // The output registers are the head entry; the skid entry only fills when the head is stalled.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         o_imm        <= '0;
         o_fmt        <= 3'd0;
         o_illegal    <= 1'b0;
         skid_imm     <= '0;
         skid_fmt     <= 3'd0;
         skid_illegal <= 1'b0;
      end else begin
         if ((state == ST_EMPTY && push) || (state == ST_ONE && push && pop)) begin
            o_imm     <= dec_imm;
            o_fmt     <= dec_fmt;
            o_illegal <= dec_illegal;
         end else if (state == ST_TWO && pop) begin
            o_imm     <= skid_imm;
            o_fmt     <= skid_fmt;
            o_illegal <= skid_illegal;
         end
         if (state == ST_ONE && push && !pop) begin
            skid_imm     <= dec_imm;
            skid_fmt     <= dec_fmt;
            skid_illegal <= dec_illegal;
         end
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst)                                       o_illegal_cnt <= '0;
      else if (i_cnt_clr)                              o_illegal_cnt <= '0;
      else if (pop && o_illegal && !(&o_illegal_cnt)) o_illegal_cnt <= o_illegal_cnt + 1'b1;
   end

endmodule

// File: tb/tb_imm_gen_pipe.sv
// tb/tb_imm_gen_pipe.sv - table-driven scoreboard bench for imm_gen_pipe at XLEN 32 and 64
module tb_imm_gen_pipe;

   typedef struct {
      logic [31:0] instr;
      logic        se;
      logic [31:0] imm32;
      logic [63:0] imm64;
      logic [2:0]  fmt;
      logic        ill32;
      logic        ill64;
   } vec_t;

   logic        clk = 1'b0;
   logic        i_rst;
   logic        i_in_valid;
   logic [31:0] i_instr;
   logic        i_signext;
   logic        i_out_ready;
   logic        i_cnt_clr;

   logic        rdy32, vld32, ill32;
   logic [31:0] imm32;
   logic [2:0]  fmt32;
   logic [1:0]  cnt32;
   logic        rdy64, vld64, ill64;
   logic [63:0] imm64;
   logic [2:0]  fmt64;
   logic [15:0] cnt64;

   int   n_checks = 0;
   int   n_fail   = 0;
   int   m32      = 0;
   int   m64      = 0;
   bit   rnd      = 1'b0;
   vec_t q[$];
   vec_t cur;
   vec_t mon_e;
   vec_t tbl[17];

   always #5 clk = ~clk;

   imm_gen_pipe #(.XLEN(32), .CNT_W(2)) dut32 (
      .i_clk(clk), .i_rst(i_rst), .i_in_valid(i_in_valid), .o_in_ready(rdy32),
      .i_instr(i_instr), .i_signext(i_signext), .o_out_valid(vld32), .i_out_ready(i_out_ready),
      .o_imm(imm32), .o_fmt(fmt32), .o_illegal(ill32), .o_illegal_cnt(cnt32), .i_cnt_clr(i_cnt_clr)
   );

   imm_gen_pipe #(.XLEN(64), .CNT_W(16)) dut64 (
      .i_clk(clk), .i_rst(i_rst), .i_in_valid(i_in_valid), .o_in_ready(rdy64),
      .i_instr(i_instr), .i_signext(i_signext), .o_out_valid(vld64), .i_out_ready(i_out_ready),
      .o_imm(imm64), .o_fmt(fmt64), .o_illegal(ill64), .o_illegal_cnt(cnt64), .i_cnt_clr(i_cnt_clr)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic vec_t mk(input logic [31:0] instr, input logic se, input logic [31:0] i32,
                               input logic [63:0] i64, input logic [2:0] f, input logic l32,
                               input logic l64);
      vec_t v;
      v.instr = instr; v.se = se; v.imm32 = i32; v.imm64 = i64;
      v.fmt = f; v.ill32 = l32; v.ill64 = l64;
      return v;
   endfunction

   // Scoreboard: compare head against the model on every cycle, then advance the model.
   always @(negedge clk) begin
      if (!i_rst) begin
         automatic bit exp_rdy = (q.size() < 2);
         chk("in_ready32", {63'd0, rdy32}, {63'd0, exp_rdy});
         chk("in_ready64", {63'd0, rdy64}, {63'd0, exp_rdy});
         chk("out_valid32", {63'd0, vld32}, {63'd0, q.size() != 0});
         chk("out_valid64", {63'd0, vld64}, {63'd0, q.size() != 0});
         chk("cnt32", {62'd0, cnt32}, 64'(m32));
         chk("cnt64", {48'd0, cnt64}, 64'(m64));
         if (q.size() != 0) begin
            mon_e = q[0];
            chk("imm32", {32'd0, imm32}, {32'd0, mon_e.imm32});
            chk("fmt32", {61'd0, fmt32}, {61'd0, mon_e.fmt});
            chk("ill32", {63'd0, ill32}, {63'd0, mon_e.ill32});
            chk("imm64", imm64, mon_e.imm64);
            chk("fmt64", {61'd0, fmt64}, {61'd0, mon_e.fmt});
            chk("ill64", {63'd0, ill64}, {63'd0, mon_e.ill64});
         end
         if (i_cnt_clr) begin
            m32 = 0;
            m64 = 0;
         end else if (i_out_ready && q.size() != 0) begin
            if (q[0].ill32 && m32 != 3)     m32++;
            if (q[0].ill64 && m64 != 65535) m64++;
         end
         if (i_out_ready && q.size() != 0) q.delete(0);
         if (i_in_valid && exp_rdy) q.push_back(cur);
      end
   end

   task automatic push(input vec_t e);
      bit done = 1'b0;
      cur        = e;
      i_instr    = e.instr;
      i_signext  = e.se;
      i_in_valid = 1'b1;
      for (int t = 0; t < 200 && !done; t++) begin
         if (rnd) i_out_ready = 1'($urandom_range(0, 1));
         @(negedge clk);
         done = rdy32;
         @(posedge clk);
         #1;
      end
      if (!done) chk("push_timeout", 64'd0, 64'd1);
      i_in_valid = 1'b0;
   endtask

   task automatic drain();
      int t = 0;
      i_out_ready = 1'b1;
      while (q.size() != 0 && t < 200) begin
         @(posedge clk);
         #1;
         t++;
      end
      if (q.size() != 0) chk("drain_timeout", 64'd0, 64'd1);
      @(posedge clk);
      #1;
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      tbl[0]  = mk(32'hFFF00093, 1, 32'hFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 3'd1, 0, 0);
      tbl[1]  = mk(32'hFFF00093, 0, 32'h00000FFF, 64'h0000000000000FFF, 3'd1, 0, 0);
      tbl[2]  = mk(32'h800000B7, 1, 32'h80000000, 64'hFFFFFFFF80000000, 3'd4, 0, 0);
      tbl[3]  = mk(32'h800000B7, 0, 32'h80000000, 64'h0000000080000000, 3'd4, 0, 0);
      tbl[4]  = mk(32'h4210D093, 1, 32'h00000001, 64'h0000000000000021, 3'd6, 1, 0);
      tbl[5]  = mk(32'hFE20AE23, 1, 32'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC, 3'd2, 0, 0);
      tbl[6]  = mk(32'hFE20AE23, 0, 32'h00000FFC, 64'h0000000000000FFC, 3'd2, 0, 0);
      tbl[7]  = mk(32'h80000FE3, 1, 32'hFFFFF81E, 64'hFFFFFFFFFFFFF81E, 3'd3, 0, 0);
      tbl[8]  = mk(32'h80000FE3, 0, 32'h0000181E, 64'h000000000000181E, 3'd3, 0, 0);
      tbl[9]  = mk(32'h800000EF, 1, 32'hFFF00000, 64'hFFFFFFFFFFF00000, 3'd5, 0, 0);
      tbl[10] = mk(32'h800000EF, 0, 32'h00100000, 64'h0000000000100000, 3'd5, 0, 0);
      tbl[11] = mk(32'h7FFFF06F, 1, 32'h000FFFFE, 64'h00000000000FFFFE, 3'd5, 0, 0);
      tbl[12] = mk(32'h002081B3, 1, 32'h00000000, 64'h0000000000000000, 3'd0, 0, 0);
      tbl[13] = mk(32'h0000007F, 1, 32'h00000000, 64'h0000000000000000, 3'd0, 1, 1);
      tbl[14] = mk(32'h00509093, 1, 32'h00000005, 64'h0000000000000005, 3'd6, 0, 0);
      tbl[15] = mk(32'h80002083, 1, 32'hFFFFF800, 64'hFFFFFFFFFFFFF800, 3'd1, 0, 0);
      tbl[16] = mk(32'h12345017, 1, 32'h12345000, 64'h0000000012345000, 3'd4, 0, 0);

      i_rst = 1'b1; i_in_valid = 1'b0; i_instr = 32'd0; i_signext = 1'b0;
      i_out_ready = 1'b1; i_cnt_clr = 1'b0;
      cur = tbl[0];
      #1;
      chk("rst_ready32", {63'd0, rdy32}, 64'd1);
      chk("rst_valid32", {63'd0, vld32}, 64'd0);
      chk("rst_imm64", imm64, 64'd0);
      chk("rst_fmt32", {61'd0, fmt32}, 64'd0);
      chk("rst_ill32", {63'd0, ill32}, 64'd0);
      chk("rst_cnt32", {62'd0, cnt32}, 64'd0);
      @(posedge clk);
      #1;
      i_rst = 1'b0;

      // back-to-back at full throughput, then with random downstream stalls
      for (int i = 0; i < 17; i++) push(tbl[i]);
      drain();
      rnd = 1'b1;
      for (int i = 0; i < 17; i++) push(tbl[16 - i]);
      rnd = 1'b0;
      drain();

      i_cnt_clr = 1'b1;
      @(posedge clk);
      #1;
      i_cnt_clr = 1'b0;

      // fill both entries with downstream stalled; a third offer must be refused
      i_out_ready = 1'b0;
      push(tbl[0]);
      push(tbl[5]);
      chk("full_ready", {63'd0, rdy32}, 64'd0);
      cur = tbl[7]; i_instr = tbl[7].instr; i_signext = tbl[7].se; i_in_valid = 1'b1;
      repeat (2) begin
         @(posedge clk);
         #1;
      end
      chk("full_hold_ready", {63'd0, rdy32}, 64'd0);
      chk("full_hold_imm", {32'd0, imm32}, 64'hFFFFFFFF);
      i_in_valid = 1'b0;
      drain();
      push(tbl[7]);
      drain();

      // illegal counter saturation, then clear racing an illegal pop
      for (int i = 0; i < 5; i++) push(tbl[13]);
      drain();
      chk("cnt_sat32", {62'd0, cnt32}, 64'd3);
      chk("cnt_run64", {48'd0, cnt64}, 64'd5);
      push(tbl[13]);
      i_cnt_clr = 1'b1;
      @(posedge clk);
      #1;
      i_cnt_clr = 1'b0;
      chk("clr_win32", {62'd0, cnt32}, 64'd0);
      chk("clr_win64", {48'd0, cnt64}, 64'd0);
      drain();

      // asynchronous reset while two entries are buffered
      i_out_ready = 1'b0;
      push(tbl[2]);
      push(tbl[9]);
      @(posedge clk);
      #2;
      i_rst = 1'b1;
      #1;
      chk("arst_valid32", {63'd0, vld32}, 64'd0);
      chk("arst_ready32", {63'd0, rdy32}, 64'd1);
      chk("arst_valid64", {63'd0, vld64}, 64'd0);
      chk("arst_ready64", {63'd0, rdy64}, 64'd1);
      chk("arst_imm64", imm64, 64'd0);
      q.delete();
      m32 = 0;
      m64 = 0;
      #1;
      i_rst = 1'b0;
      i_out_ready = 1'b1;
      repeat (4) begin
         @(posedge clk);
         #1;
         chk("post_rst_valid", {63'd0, vld32}, 64'd0);
      end
      push(tbl[11]);
      drain();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/imm_gen_pipe.md
IMM_GEN_PIPE -- requirements
Module: imm_gen_pipe

Interface
REQ-001 SHALL have parameter XLEN, default 32, immediate output width; legal values 32 and 64.
REQ-002 SHALL have parameter CNT_W, default 16, width of the illegal-instruction counter.
REQ-003 SHALL have port i_clk, input, 1, the single clock; all state updates on the rising edge.
REQ-004 SHALL have port i_rst, input, 1; reset is asynchronous and active-high.
REQ-005 SHALL have port i_in_valid, input, 1, upstream instruction valid.
REQ-006 SHALL have port o_in_ready, input-side ready, output, 1, registered.
REQ-007 SHALL have port i_instr, input, 32, instruction word.
REQ-008 SHALL have port i_signext, input, 1; 1 = sign-extend, 0 = zero-extend; sampled together with i_instr.
REQ-009 SHALL have port o_out_valid, output, 1, result valid.
REQ-010 SHALL have port i_out_ready, input, 1, downstream ready.
REQ-011 SHALL have port o_imm, output, XLEN, decoded immediate.
REQ-012 SHALL have port o_fmt, output, 3, format code: NONE=0, I=1, S=2, B=3, U=4, J=5, SHAMT=6.
REQ-013 SHALL have port o_illegal, output, 1, unsupported opcode or shamt.
REQ-014 SHALL have port o_illegal_cnt, output, CNT_W, saturating count of illegal results delivered.
REQ-015 SHALL have port i_cnt_clr, input, 1, synchronous counter clear.

Function
REQ-016 Decode: opcodes 0000011/1100111 -> I; 0010011 -> I, except funct3 001/101 -> SHAMT; 0100011 -> S; 1100011 -> B; 0110111/0010111 (LUI/AUIPC) -> U; 1101111 -> J; 0110011 -> NONE, imm 0, not illegal.
REQ-017 Any other opcode SHALL give fmt NONE, imm 0, o_illegal=1.
REQ-018 I/S/B/J fields are the standard RV32I bit layouts; B and J bit0 = 0; extension bits to XLEN = instr[31] AND i_signext.
REQ-019 U: instr[31:12] shifted left 12, bits above 31 = instr[31] AND i_signext.
REQ-020 SHAMT: zero-extended instr[24:20] for XLEN=32, instr[25:20] for XLEN=64; for XLEN=32, instr[25]=1 SHALL set o_illegal=1 and keep fmt SHAMT.
REQ-021 Input handshake: transfer on the edge where i_in_valid and o_in_ready are both 1; output handshake: o_out_valid and i_out_ready both 1.
REQ-022 Latency: an instruction accepted at edge k appears on the outputs after edge k when the buffer is empty; throughput one per cycle with i_out_ready held at 1.
REQ-023 Buffer is a 2-entry skid FIFO with states EMPTY, ONE, TWO; push-only advances one state; pop-only retreats one state; push+pop holds the state.
REQ-024 o_in_ready SHALL be 0 exactly when the state is TWO; a push is never accepted in TWO.
REQ-025 While o_out_valid=1 and i_out_ready=0, o_imm/o_fmt/o_illegal SHALL hold stable.
REQ-026 Results SHALL leave in acceptance order.
REQ-027 Counter increments by 1 on each output handshake with o_illegal=1 and saturates at 2^CNT_W-1; i_cnt_clr forces 0 and wins over a simultaneous increment.

Reset
REQ-028 On i_rst=1, immediately and without a clock: state EMPTY, o_out_valid=0, o_in_ready=1, o_imm=0, o_fmt=0, o_illegal=0, o_illegal_cnt=0.
REQ-029 Reset asserted mid-operation SHALL drop all buffered entries; no result is emitted after reset releases until a new push.

Structure
REQ-030 Shared package imm_pkg SHALL hold the opcode constants, the fmt encoding and the buffer-state encoding.
REQ-031 A combinational sub-module imm_fmt_decode (instr, signext -> imm, fmt, illegal, parameter XLEN) SHALL perform the decode; imm_gen_pipe registers its outputs into the skid FIFO.

Verification
REQ-032 XLEN=32, i_instr=0xFFF00093, i_signext=1 -> next cycle o_imm=0xFFFFFFFF, o_fmt=1, o_illegal=0; same instruction with i_signext=0 -> o_imm=0x00000FFF.
REQ-033 XLEN=64, LUI 0x800000B7, i_signext=1 -> o_imm=0xFFFFFFFF80000000, o_fmt=4; XLEN=64, SRAI with shamt 33 (0x4210D093) -> o_imm=33, o_fmt=6, o_illegal=0; the same word under XLEN=32 -> o_illegal=1.
REQ-034 i_out_ready=0, three back-to-back pushes -> o_in_ready=0 after the second push, third not accepted; raise i_out_ready -> first two results in order, then the third is accepted on the next push.
REQ-035 CNT_W=2, five pushes of 0x0000007F with i_out_ready=1 -> o_illegal=1 each, o_illegal_cnt saturates at 3; i_cnt_clr coincident with an illegal pop -> count 0.
REQ-036 State TWO, assert i_rst between clock edges -> o_out_valid=0 and o_in_ready=1 without a clock edge; after release with no push, o_out_valid stays 0.
